// File: rtl/fetch_unit_if.sv
// Instruction memory port between the fetch stage (master) and the memory (slave).
interface fetch_unit_if;
  logic        read;
  logic [31:0] address;
  logic [31:0] rdata;
  logic        resp;

  modport master (output read, output address, input rdata, input resp);
  modport slave  (input read, input address, output rdata, output resp);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives imem, feeds IF/ID with instruction, PC and load strobe.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0060,
  parameter logic [31:0] INSTR_NOP = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic [31:0]         ir_out,
  output logic [31:0]         pc_out,
  output logic                valid_out,
  output logic                load_if_id,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_wait
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] drain_addr_r, drain_addr_s;
  logic [31:0] hold_ir_r, hold_ir_s;
  logic [31:0] hold_pc_r, hold_pc_s;
  logic        read_s;
  logic [31:0] addr_s;
  logic [31:0] ir_s;
  logic [31:0] pc_out_s;
  logic        valid_s;

  // State, PC, drain address and hold buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      drain_addr_r <= RESET_PC;
      hold_ir_r    <= INSTR_NOP;
      hold_pc_r    <= RESET_PC;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      drain_addr_r <= drain_addr_s;
      hold_ir_r    <= hold_ir_s;
      hold_pc_r    <= hold_pc_s;
    end
  end

  // Next-state and output decode; redirect beats stall beats advance
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    drain_addr_s = drain_addr_r;
    hold_ir_s    = hold_ir_r;
    hold_pc_s    = hold_pc_r;
    read_s       = 1'b0;
    addr_s       = pc_r;
    ir_s         = INSTR_NOP;
    pc_out_s     = pc_r;
    valid_s      = 1'b0;
    case (state_r)
      ST_FETCH: begin
        read_s = 1'b1;
        if (redirect) begin
          pc_s = redirect_pc;
          if (imem.resp) begin
            state_s = ST_FETCH;
          end else begin
            // The read in flight must still complete at the old address.
            drain_addr_s = pc_r;
            state_s      = ST_DRAIN;
          end
        end else if (imem.resp) begin
          ir_s    = imem.rdata;
          valid_s = 1'b1;
          if (stall) begin
            hold_ir_s = imem.rdata;
            hold_pc_s = pc_r;
            state_s   = ST_HOLD;
          end else begin
            pc_s = pc_r + 32'd4;
          end
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_s    = redirect_pc;
          state_s = ST_FETCH;
        end else begin
          ir_s     = hold_ir_r;
          pc_out_s = hold_pc_r;
          valid_s  = 1'b1;
          if (!stall) begin
            pc_s    = pc_r + 32'd4;
            state_s = ST_FETCH;
          end else begin
            state_s = ST_HOLD;
          end
        end
      end
      ST_DRAIN: begin
        read_s = 1'b1;
        addr_s = drain_addr_r;
        if (redirect) begin
          pc_s = redirect_pc;
        end else begin
          pc_s = pc_r;
        end
        if (imem.resp) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_FETCH;
      end
    endcase
  end

  assign imem.read    = rst & read_s;
  assign imem.address = addr_s;
  assign valid_out    = rst & valid_s;
  assign ir_out       = (rst && valid_s) ? ir_s : INSTR_NOP;
  assign pc_out       = pc_out_s;
  assign load_if_id   = rst & ~stall;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_r;
  logic [31:0] wait_r;

  // Delivered-instruction and memory-wait cycle counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_r <= 32'd0;
      wait_r    <= 32'd0;
    end else begin
      if (valid_out && load_if_id) begin
        fetched_r <= fetched_r + 32'd1;
      end else begin
        fetched_r <= fetched_r;
      end
      if (imem.read && !imem.resp) begin
        wait_r <= wait_r + 32'd1;
      end else begin
        wait_r <= wait_r;
      end
    end
  end

  assign perf_fetched = fetched_r;
  assign perf_wait    = wait_r;
`else
  assign perf_fetched = 32'd0;
  assign perf_wait    = 32'd0;
`endif

endmodule
